// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data memory arbiter; one instance per master.
// The master modport is the requester's view, the slave modport is the arbiter's view.
interface dmem_arbiter_if;
   logic        req;
   logic        lock;
   logic [31:0] addr;
   logic        wr_en;
   logic [63:0] wdata;
   logic [7:0]  wmask;
   logic        gnt;
   logic        rvalid;
   logic [63:0] rdata;

   modport master (
      output req, lock, addr, wr_en, wdata, wmask,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, lock, addr, wr_en, wdata, wmask,
      output gnt, rvalid, rdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one 64-bit synchronous data RAM port between the
// processor load/store port (m0) and the loader/debug port (m1), with bounded lock bursts.
module dmem_arbiter #(
   parameter int MAX_BURST = 8,
   parameter int CNT_WID   = 4
) (
   input  logic                 clk,
   input  logic                 nrst,
   dmem_arbiter_if.slave        m0,
   dmem_arbiter_if.slave        m1,
   output logic [31:0]          mem_addr,
   output logic                 mem_wr_en,
   output logic [63:0]          mem_wdata,
   output logic [7:0]           mem_wmask,
   input  logic [63:0]          mem_rdata
);

   localparam logic [CNT_WID-1:0] BURST_MAX = CNT_WID'(MAX_BURST);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   state_t               state;
   state_t               own_sel;
   logic [CNT_WID-1:0]   beat_cnt;
   logic                 last_gnt;
   logic [1:0]           rd_pend_p1;
   logic                 idle_g0;
   logic                 idle_g1;
   logic                 gnt0;
   logic                 gnt1;
   logic                 gnt_any;
   logic                 gnt_lock;
   logic                 rvalid0;
   logic                 rvalid1;
   logic                 unused_addr_lsb;

   function automatic logic [CNT_WID-1:0] sat_inc(input logic [CNT_WID-1:0] c);
      if (c >= BURST_MAX)
         return BURST_MAX;
      return c + 1'b1;
   endfunction

   // Free arbitration: a lone requester wins, a tie goes to whoever was not served last.
   assign idle_g0 = m0.req & (~m1.req | last_gnt);
   assign idle_g1 = m1.req & (~m0.req | ~last_gnt);

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      case (state)
         OWN0: begin
            if (m0.req) begin
               if (beat_cnt == BURST_MAX && m1.req)
                  gnt1 = 1'b1;
               else
                  gnt0 = 1'b1;
            end else begin
               gnt0 = idle_g0;
               gnt1 = idle_g1;
            end
         end
         OWN1: begin
            if (m1.req) begin
               if (beat_cnt == BURST_MAX && m0.req)
                  gnt0 = 1'b1;
               else
                  gnt1 = 1'b1;
            end else begin
               gnt0 = idle_g0;
               gnt1 = idle_g1;
            end
         end
         default: begin
            gnt0 = idle_g0;
            gnt1 = idle_g1;
         end
      endcase
      if (!nrst) begin
         gnt0 = 1'b0;
         gnt1 = 1'b0;
      end
   end

   assign gnt_any  = gnt0 | gnt1;
   assign gnt_lock = (gnt0 & m0.lock) | (gnt1 & m1.lock);
   assign own_sel  = gnt1 ? OWN1 : OWN0;

   always_comb begin
      mem_addr  = '0;
      mem_wr_en = 1'b0;
      mem_wdata = '0;
      mem_wmask = '0;
      if (gnt0) begin
         mem_addr  = {m0.addr[31:3], 3'b000};
         mem_wr_en = m0.wr_en;
         mem_wdata = m0.wdata;
         mem_wmask = m0.wmask;
      end else if (gnt1) begin
         mem_addr  = {m1.addr[31:3], 3'b000};
         mem_wr_en = m1.wr_en;
         mem_wdata = m1.wdata;
         mem_wmask = m1.wmask;
      end
   end

   // Stage p0 -> p1: control state and read-return tracking.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         state      <= IDLE;
         beat_cnt   <= '0;
         last_gnt   <= 1'b1;
         rd_pend_p1 <= 2'b00;
      end else begin
         rd_pend_p1 <= {gnt1 & ~m1.wr_en, gnt0 & ~m0.wr_en};
         if (gnt_any)
            last_gnt <= gnt1;
         if (gnt_lock) begin
            state    <= own_sel;
            beat_cnt <= (state == own_sel) ? sat_inc(beat_cnt) : CNT_WID'(1);
         end else begin
            state    <= IDLE;
            beat_cnt <= '0;
         end
      end
   end

   // Stage p1: RAM data returns to whichever master issued the read.
   assign rvalid0   = rd_pend_p1[0] & nrst;
   assign rvalid1   = rd_pend_p1[1] & nrst;
   assign m0.gnt    = gnt0;
   assign m1.gnt    = gnt1;
   assign m0.rvalid = rvalid0;
   assign m1.rvalid = rvalid1;
   assign m0.rdata  = rvalid0 ? mem_rdata : '0;
   assign m1.rdata  = rvalid1 ? mem_rdata : '0;

   assign unused_addr_lsb = ^{m0.addr[2:0], m1.addr[2:0]};

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small byte-masked synchronous RAM model.
module tb_dmem_arbiter;
   logic        clk;
   logic        nrst;
   logic [31:0] mem_addr;
   logic        mem_wr_en;
   logic [63:0] mem_wdata;
   logic [7:0]  mem_wmask;
   logic [63:0] mem_rdata;
   logic [63:0] ram [0:127];
   logic        ram_loaded = 1'b0;
   int          n_pass = 0;
   int          n_chk  = 0;

   dmem_arbiter_if m0_if ();
   dmem_arbiter_if m1_if ();

   dmem_arbiter #(.MAX_BURST(8), .CNT_WID(4)) dut (
      .clk       (clk),
      .nrst      (nrst),
      .m0        (m0_if),
      .m1        (m1_if),
      .mem_addr  (mem_addr),
      .mem_wr_en (mem_wr_en),
      .mem_wdata (mem_wdata),
      .mem_wmask (mem_wmask),
      .mem_rdata (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM preloaded with word i = A5A5_0000_<i>.
   always @(posedge clk) begin
      if (!ram_loaded) begin
         for (int i = 0; i < 128; i++) ram[i] <= {32'hA5A5_0000, 32'(i)};
         ram_loaded <= 1'b1;
      end else if (mem_wr_en) begin
         for (int b = 0; b < 8; b++)
            if (mem_wmask[b]) ram[mem_addr[9:3]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
      mem_rdata <= ram[mem_addr[9:3]];
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all;
      m0_if.req = 0; m0_if.lock = 0; m0_if.addr = 0; m0_if.wr_en = 0; m0_if.wdata = 0; m0_if.wmask = 0;
      m1_if.req = 0; m1_if.lock = 0; m1_if.addr = 0; m1_if.wr_en = 0; m1_if.wdata = 0; m1_if.wmask = 0;
   endtask

   task automatic do_reset;
      idle_all();
      nrst = 0;
      tick();
      tick();
      nrst = 1;
   endtask

   task automatic test_reset;
      idle_all();
      nrst = 0;
      m0_if.req = 1; m0_if.wr_en = 1; m0_if.addr = 32'h18; m0_if.wmask = 8'hFF; m0_if.wdata = 64'h1234;
      m1_if.req = 1;
      #1;
      n_chk++; if (m0_if.gnt !== 1'b0) $display("FAIL rst_gnt0: got %b want 0", m0_if.gnt); else n_pass++;
      n_chk++; if (m1_if.gnt !== 1'b0) $display("FAIL rst_gnt1: got %b want 0", m1_if.gnt); else n_pass++;
      n_chk++; if ({mem_wr_en, mem_wmask, mem_addr} !== 41'd0) $display("FAIL rst_mem: got we=%b mask=%h addr=%h want 0", mem_wr_en, mem_wmask, mem_addr); else n_pass++;
      n_chk++; if (mem_wdata !== 64'd0) $display("FAIL rst_wdata: got %h want 0", mem_wdata); else n_pass++;
      tick();
      tick();
      n_chk++; if ({m0_if.rvalid, m1_if.rvalid} !== 2'b00) $display("FAIL rst_rvalid: got %b want 00", {m0_if.rvalid, m1_if.rvalid}); else n_pass++;
      n_chk++; if (dut.beat_cnt !== 4'd0) $display("FAIL rst_cnt: got %0d want 0", dut.beat_cnt); else n_pass++;
      idle_all();
      nrst = 1;
      tick();
   endtask

   task automatic test_read;
      do_reset();
      m0_if.req = 1; m0_if.addr = 32'h0000_0013;
      #1;
      n_chk++; if ({m0_if.gnt, m1_if.gnt} !== 2'b10) $display("FAIL rd_gnt: got %b want 10", {m0_if.gnt, m1_if.gnt}); else n_pass++;
      n_chk++; if (mem_addr !== 32'h10) $display("FAIL rd_addr: got %h want 00000010", mem_addr); else n_pass++;
      n_chk++; if (mem_wr_en !== 1'b0) $display("FAIL rd_we: got %b want 0", mem_wr_en); else n_pass++;
      tick();
      idle_all();
      #1;
      n_chk++; if (m0_if.rvalid !== 1'b1) $display("FAIL rd_rvalid: got %b want 1", m0_if.rvalid); else n_pass++;
      n_chk++; if (m0_if.rdata !== 64'hA5A5_0000_0000_0002) $display("FAIL rd_data: got %h want a5a5000000000002", m0_if.rdata); else n_pass++;
      n_chk++; if (m1_if.rvalid !== 1'b0) $display("FAIL rd_m1_rvalid: got %b want 0", m1_if.rvalid); else n_pass++;
      tick();
      #1;
      n_chk++; if ({m0_if.rvalid, m0_if.rdata} !== 65'd0) $display("FAIL rd_rvalid_drop: got %b/%h want 0/0", m0_if.rvalid, m0_if.rdata); else n_pass++;
   endtask

   task automatic test_round_robin;
      logic e0;
      do_reset();
      m0_if.req = 1; m0_if.wr_en = 1; m0_if.addr = 32'h40; m0_if.wdata = 64'h77; m0_if.wmask = 8'h0F;
      m1_if.req = 1; m1_if.wr_en = 0; m1_if.addr = 32'h08;
      for (int i = 0; i < 4; i++) begin
         e0 = (i % 2 == 0);
         #1;
         n_chk++; if ({m0_if.gnt, m1_if.gnt} !== {e0, ~e0}) $display("FAIL rr_gnt%0d: got %b want %b", i, {m0_if.gnt, m1_if.gnt}, {e0, ~e0}); else n_pass++;
         n_chk++; if (mem_wr_en !== e0) $display("FAIL rr_we%0d: got %b want %b", i, mem_wr_en, e0); else n_pass++;
         n_chk++; if (mem_addr !== (e0 ? 32'h40 : 32'h08)) $display("FAIL rr_addr%0d: got %h want %h", i, mem_addr, e0 ? 32'h40 : 32'h08); else n_pass++;
         if (i == 2) begin
            n_chk++; if (m1_if.rdata !== 64'hA5A5_0000_0000_0001) $display("FAIL rr_m1_data: got %h want a5a5000000000001", m1_if.rdata); else n_pass++;
         end
         tick();
      end
      idle_all();
   endtask

   task automatic test_lock_burst;
      int  eb;
      logic e0;
      do_reset();
      for (int c = 0; c < 13; c++) begin
         eb = (c < 8) ? c : c - 1;
         e0 = (c == 8);
         m1_if.req = 1; m1_if.wr_en = 1; m1_if.wmask = 8'hFF;
         m1_if.addr = 32'h100 + 32'(eb * 8); m1_if.lock = (eb < 11);
         m1_if.wdata = {32'hB0B0_0000, 32'(eb)};
         m0_if.req = (c >= 1 && c <= 8); m0_if.addr = 32'h200;
         #1;
         n_chk++; if ({m0_if.gnt, m1_if.gnt} !== {e0, ~e0}) $display("FAIL lk_gnt%0d: got %b want %b", c, {m0_if.gnt, m1_if.gnt}, {e0, ~e0}); else n_pass++;
         if (c == 9) begin
            n_chk++; if (m0_if.rdata !== 64'hA5A5_0000_0000_0040 || m0_if.rvalid !== 1'b1) $display("FAIL lk_m0_read: got %b/%h want 1/a5a5000000000040", m0_if.rvalid, m0_if.rdata); else n_pass++;
         end
         tick();
      end
      idle_all();
      #1;
      n_chk++; if (dut.beat_cnt !== 4'd0) $display("FAIL lk_cnt_end: got %0d want 0", dut.beat_cnt); else n_pass++;
      n_chk++; if (ram[43] !== 64'hB0B0_0000_0000_000B) $display("FAIL lk_ram_last: got %h want b0b000000000000b", ram[43]); else n_pass++;
      n_chk++; if (ram[32] !== 64'hB0B0_0000_0000_0000) $display("FAIL lk_ram_first: got %h want b0b0000000000000", ram[32]); else n_pass++;
   endtask

   task automatic test_lock_saturate;
      do_reset();
      for (int c = 0; c < 12; c++) begin
         m1_if.req = 1; m1_if.wr_en = 0; m1_if.addr = 32'h300 + 32'(c * 8); m1_if.lock = (c < 11);
         #1;
         n_chk++; if ({m0_if.gnt, m1_if.gnt} !== 2'b01) $display("FAIL sat_gnt%0d: got %b want 01", c, {m0_if.gnt, m1_if.gnt}); else n_pass++;
         if (c >= 1) begin
            n_chk++; if (m1_if.rdata !== {32'hA5A5_0000, 32'(96 + c - 1)}) $display("FAIL sat_data%0d: got %h want %h", c, m1_if.rdata, {32'hA5A5_0000, 32'(96 + c - 1)}); else n_pass++;
         end
         if (c >= 10) begin
            n_chk++; if (dut.beat_cnt !== 4'd8) $display("FAIL sat_cnt%0d: got %0d want 8", c, dut.beat_cnt); else n_pass++;
         end
         tick();
      end
      idle_all();
      #1;
      n_chk++; if (m1_if.rvalid !== 1'b1) $display("FAIL sat_last_rvalid: got %b want 1", m1_if.rvalid); else n_pass++;
      n_chk++; if (dut.beat_cnt !== 4'd0) $display("FAIL sat_cnt_idle: got %0d want 0", dut.beat_cnt); else n_pass++;
      tick();
   endtask

   task automatic test_write_read;
      do_reset();
      m0_if.req = 1; m0_if.wr_en = 1; m0_if.addr = 32'h20; m0_if.wmask = 8'hFF; m0_if.wdata = 64'hDEAD_BEEF_0123_4567;
      #1;
      n_chk++; if ({m0_if.gnt, mem_wr_en, mem_wmask} !== {2'b11, 8'hFF}) $display("FAIL wr_strobe: got gnt=%b we=%b mask=%h want 1/1/ff", m0_if.gnt, mem_wr_en, mem_wmask); else n_pass++;
      n_chk++; if (mem_wdata !== 64'hDEAD_BEEF_0123_4567) $display("FAIL wr_data: got %h want deadbeef01234567", mem_wdata); else n_pass++;
      tick();
      idle_all();
      m1_if.req = 1; m1_if.addr = 32'h20;
      #1;
      n_chk++; if ({m0_if.rvalid, m1_if.gnt, mem_wr_en} !== 3'b010) $display("FAIL wr_follow: got rv0=%b gnt1=%b we=%b want 0/1/0", m0_if.rvalid, m1_if.gnt, mem_wr_en); else n_pass++;
      tick();
      idle_all();
      #1;
      n_chk++; if (m1_if.rvalid !== 1'b1 || m1_if.rdata !== 64'hDEAD_BEEF_0123_4567) $display("FAIL wr_readback: got %b/%h want 1/deadbeef01234567", m1_if.rvalid, m1_if.rdata); else n_pass++;
   endtask

   task automatic test_reset_mid_burst;
      do_reset();
      m1_if.req = 1; m1_if.lock = 1; m1_if.addr = 32'h30;
      #1;
      n_chk++; if (m1_if.gnt !== 1'b1) $display("FAIL rmb_first: got %b want 1", m1_if.gnt); else n_pass++;
      tick();
      nrst = 0;
      m1_if.wr_en = 1; m1_if.wmask = 8'hFF; m1_if.wdata = 64'hBAD;
      #1;
      n_chk++; if ({m0_if.gnt, m1_if.gnt, m1_if.rvalid, mem_wr_en} !== 4'b0000) $display("FAIL rmb_forced: got gnt=%b%b rv1=%b we=%b want 0000", m0_if.gnt, m1_if.gnt, m1_if.rvalid, mem_wr_en); else n_pass++;
      tick();
      nrst = 1;
      m1_if.wr_en = 0; m1_if.lock = 1;
      m0_if.req = 1; m0_if.addr = 32'h00;
      #1;
      n_chk++; if ({m0_if.gnt, m1_if.gnt} !== 2'b10) $display("FAIL rmb_tie: got %b want 10", {m0_if.gnt, m1_if.gnt}); else n_pass++;
      n_chk++; if (m1_if.rvalid !== 1'b0) $display("FAIL rmb_discard: got %b want 0", m1_if.rvalid); else n_pass++;
      n_chk++; if (ram[6] !== 64'hA5A5_0000_0000_0006) $display("FAIL rmb_nowrite: got %h want a5a5000000000006", ram[6]); else n_pass++;
      tick();
      idle_all();
   endtask

   task automatic test_back_to_back;
      do_reset();
      m0_if.req = 1; m0_if.lock = 1; m0_if.addr = 32'h08;
      #1;
      n_chk++; if (m0_if.gnt !== 1'b1) $display("FAIL b2b_first: got %b want 1", m0_if.gnt); else n_pass++;
      tick();
      m0_if.lock = 0; m0_if.addr = 32'h10;
      m1_if.req = 1; m1_if.addr = 32'h18;
      #1;
      n_chk++; if ({m0_if.gnt, m1_if.gnt} !== 2'b10) $display("FAIL b2b_release: got %b want 10", {m0_if.gnt, m1_if.gnt}); else n_pass++;
      n_chk++; if (m0_if.rdata !== 64'hA5A5_0000_0000_0001) $display("FAIL b2b_data1: got %h want a5a5000000000001", m0_if.rdata); else n_pass++;
      tick();
      #1;
      n_chk++; if ({m0_if.gnt, m1_if.gnt} !== 2'b01) $display("FAIL b2b_handoff: got %b want 01", {m0_if.gnt, m1_if.gnt}); else n_pass++;
      n_chk++; if (m0_if.rdata !== 64'hA5A5_0000_0000_0002) $display("FAIL b2b_data2: got %h want a5a5000000000002", m0_if.rdata); else n_pass++;
      tick();
      idle_all();
      #1;
      n_chk++; if ({m0_if.rvalid, m1_if.rvalid} !== 2'b01 || m1_if.rdata !== 64'hA5A5_0000_0000_0003) $display("FAIL b2b_m1_data: got %b/%h want 01/a5a5000000000003", {m0_if.rvalid, m1_if.rvalid}, m1_if.rdata); else n_pass++;
   endtask

   initial begin
      nrst = 0;
      idle_all();
      test_reset();
      test_read();
      test_round_robin();
      test_lock_burst();
      test_lock_saturate();
      test_write_read();
      test_reset_mid_burst();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single 64-bit data memory port between two requesters.
- Master 0 is the processor load/store port. Master 1 is the program/data loader (DMA-style initialiser and debug access).
- Arbitration is round-robin per access. A master may lock the port for a bounded burst.
- Sits between the processor's addr/wr_en/wdata/wmask/rdata port and the synchronous data RAM, which has 1-cycle read latency.

Parameters:
- MAX_BURST, 8, maximum consecutive granted beats for a locking master before it must yield to a waiting master (1..15).
- CNT_WID, 4, width of the burst beat counter; must satisfy 2^CNT_WID > MAX_BURST.

Ports:
- clk  in  1  clock; all state updates on rising edge
- nrst  in  1  synchronous active-low reset
- m0_req  in  1  master 0 requests an access this cycle
- m0_lock  in  1  master 0 requests to keep ownership after this beat
- m0_addr  in  32  master 0 byte address
- m0_wr_en  in  1  master 0 write (1) / read (0)
- m0_wdata  in  64  master 0 write data
- m0_wmask  in  8  master 0 byte-lane write mask
- m0_gnt  out  1  master 0 access accepted this cycle
- m0_rvalid  out  1  master 0 read data valid (cycle after a granted read)
- m0_rdata  out  64  master 0 read data
- m1_req, m1_lock, m1_addr, m1_wr_en, m1_wdata, m1_wmask, m1_gnt, m1_rvalid, m1_rdata: identical to the m0 set, for master 1
- mem_addr  out  32  RAM address, doubleword aligned
- mem_wr_en  out  1  RAM write strobe
- mem_wdata  out  64  RAM write data
- mem_wmask  out  8  RAM byte mask
- mem_rdata  in  64  RAM read data, valid the cycle after the address

Behaviour:
- Reset (nrst=0 sampled at a clock edge):
  - state=IDLE, beat_cnt=0, last_gnt=1 (so m0 wins the first tie), rd_pend=00.
  - While nrst=0, all gnt, rvalid, mem_wr_en, mem_addr, mem_wdata and mem_wmask are forced to 0.
- States:
  - IDLE: no owner.
  - OWN0 / OWN1: master 0 / master 1 holds a lock.
- Grant (combinational, same cycle as req):
  - At most one gnt is high per cycle.
  - IDLE, single requester: grant it.
  - IDLE, both requesting: grant the master not equal to last_gnt.
  - OWNn: grant master n if it requests. If it does not request, return to IDLE the same cycle and arbitrate as IDLE.
  - OWNn, beat_cnt==MAX_BURST and the other master requests: grant the other master and go to IDLE. The yielding master may re-lock later through normal arbitration.
- Memory mux:
  - The granted master's signals drive mem_*.
  - mem_addr = {addr[31:3],3'b000}.
  - mem_wr_en = gnt & wr_en.
  - With no grant, all mem_* outputs are 0.
- State update at the clock edge:
  - On a grant to n: last_gnt<=n.
  - If lock_n is asserted with the grant: state<=OWNn and beat_cnt<=beat_cnt+1, with beat_cnt set to 1 on the first beat of ownership.
  - If lock_n is deasserted with the grant: state<=IDLE and beat_cnt<=0.
  - beat_cnt saturates at MAX_BURST.
- Read return:
  - rd_pend[n]<=gnt_n & ~wr_en_n.
  - mn_rvalid=rd_pend[n]; mn_rdata=mem_rdata when rd_pend[n], else 0.
  - Fixed latency of 1 cycle. Back-to-back reads return one per cycle.
- Writes: complete in the grant cycle; no rvalid.
- A master whose req is not granted must hold all of its request signals stable until gnt.
- Reset mid-burst: the lock is dropped, any pending rvalid is discarded, and no memory write occurs in the reset cycle.
- Simultaneous: m0 lock release and m1 req in the same cycle gives m1 the grant on the next cycle, not this one (m0 still owns this beat).

Test Plan:
- Reset, then m0 reads addr 0x0000_0013 → mem_addr=0x10, m0_gnt=1 same cycle; next cycle m0_rvalid=1 with m0_rdata=mem_rdata, m1_rvalid=0.
- Both req continuously with no locks → grants alternate m0,m1,m0,m1 starting with m0; mem_wr_en follows the granted master's wr_en only.
- m1 locks a 12-beat write burst to 0x100..0x158 while m0 waits → m1 gets 8 grants, m0 gets one, then m1 resumes; m0 waits ≤8 cycles.
- m1 locks, m0 idle → m1 keeps the grant for all 12 beats, beat_cnt saturates at 8; drop lock → IDLE.
- m0 sd with wmask=0xFF, data 0xDEAD_BEEF_0123_4567 to 0x20 → mem_wr_en=1 for one cycle with mask 0xFF; a later m1 read of 0x20 returns that data with m1_rvalid one cycle after grant.
- nrst=0 asserted during OWN1 with a read pending → next cycle all gnt/rvalid=0 and state IDLE; the first tie after reset goes to m0.
